// File: rtl/lut_sequencer_pkg.sv
// Shared types and field layout for the LUT sequencer and its entry decoder.
package lut_sequencer_pkg;

   localparam int ENTRY_W = 40;
   localparam int DUR_W   = 24;

   // Bit offsets of each field inside a 40-bit table entry
   localparam int DUR_LSB = 16;
   localparam int CA_LSB  = 12;
   localparam int CB_LSB  = 8;
   localparam int CC_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      RUN   = 2'd2
   } state_e;

   typedef struct packed {
      logic [DUR_W-1:0] dur;
      logic [3:0]       ca;
      logic [3:0]       cb;
      logic [7:0]       cc;
   } entry_t;

endpackage

// File: rtl/lut_entry_unpack.sv
// Splits a raw table word into its fields and flags the terminator entry.
module lut_entry_unpack
   import lut_sequencer_pkg::*;
(
   input  logic [ENTRY_W-1:0] word_i,
   output entry_t             entry_o,
   output logic               is_term_o
);

   // Pure field extraction; a zero duration marks the end of the sequence
   always_comb begin
      entry_o.dur = word_i[DUR_LSB +: DUR_W];
      entry_o.ca  = word_i[CA_LSB +: 4];
      entry_o.cb  = word_i[CB_LSB +: 4];
      entry_o.cc  = word_i[CC_LSB +: 8];
      is_term_o   = (word_i[DUR_LSB +: DUR_W] == '0);
   end

endmodule

// File: rtl/lut_sequencer.sv
// Plays a lookup table of timed control patterns: each entry's control fields
// are held for its duration, with the next entry prefetched so playback is gapless.
module lut_sequencer #(
   parameter int                          ADDR_W     = 20,
   parameter int                          DUR_W      = lut_sequencer_pkg::DUR_W,
   parameter logic [ADDR_W-1:0]           START_ADDR = 1,
   parameter logic [ADDR_W-1:0]           ADDR_MAX   = '1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                abort,
   input  logic                                loop_en,
   output logic [ADDR_W-1:0]                   lut_addr,
   input  logic [lut_sequencer_pkg::ENTRY_W-1:0] lut_dout,
   input  logic                                lut_vital,
   output logic [3:0]                          ctrl_a,
   output logic [3:0]                          ctrl_b,
   output logic [7:0]                          ctrl_c,
   output logic                                busy,
   output logic                                done,
   output logic                                err
);

   import lut_sequencer_pkg::*;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DUR_W-1:0]  cnt_q;
   logic [3:0]        ca_q;
   logic [3:0]        cb_q;
   logic [7:0]        cc_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              last_q;   // entry on the outputs came from ADDR_MAX

   entry_t            entry;
   logic              is_term;
   logic              sample_en;

   lut_entry_unpack u_unpack (
      .word_i    (lut_dout),
      .entry_o   (entry),
      .is_term_o (is_term)
   );

   // The table is examined in FETCH and in the last cycle of a RUN entry
   always_comb begin
      sample_en = (state_q == FETCH) ||
                  ((state_q == RUN) && (cnt_q == DUR_W'(1)));
   end

   // Sequencer FSM with registered pattern and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         ca_q    <= '0;
         cb_q    <= '0;
         cc_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            cc_q    <= '0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
         end else if (state_q == IDLE) begin
            if (start) begin
               state_q <= FETCH;
               addr_q  <= START_ADDR;
               err_q   <= 1'b0;
               busy_q  <= 1'b1;
               last_q  <= 1'b0;
            end
         end else if (sample_en) begin
            if (((state_q == RUN) && last_q) || !lut_vital) begin
               // Walked off the end of the table, or the table is not valid
               state_q <= IDLE;
               cnt_q   <= '0;
               ca_q    <= '0;
               cb_q    <= '0;
               cc_q    <= '0;
               busy_q  <= 1'b0;
               err_q   <= 1'b1;
               last_q  <= 1'b0;
            end else if (is_term) begin
               // Terminator fields become the idle pattern
               ca_q   <= entry.ca;
               cb_q   <= entry.cb;
               cc_q   <= entry.cc;
               cnt_q  <= '0;
               done_q <= 1'b1;
               last_q <= 1'b0;
               if (loop_en) begin
                  state_q <= FETCH;
                  addr_q  <= START_ADDR;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end else begin
               ca_q    <= entry.ca;
               cb_q    <= entry.cb;
               cc_q    <= entry.cc;
               cnt_q   <= entry.dur;
               state_q <= RUN;
               last_q  <= (addr_q == ADDR_MAX);
               if (addr_q != ADDR_MAX) begin
                  addr_q <= addr_q + 1'b1;
               end
            end
         end else if (state_q == RUN) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign lut_addr = addr_q;
   assign ctrl_a   = ca_q;
   assign ctrl_b   = cb_q;
   assign ctrl_c   = cc_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_lut_sequencer.sv
// Directed bench for lut_sequencer: a behavioural table drives lut_dout and
// outputs are compared on the falling edge against hand-computed values.
module tb_lut_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        loop_en = 1'b0;
   logic [19:0] lut_addr;
   logic [39:0] lut_dout;
   logic        lut_vital;
   logic [3:0]  ctrl_a;
   logic [3:0]  ctrl_b;
   logic [7:0]  ctrl_c;
   logic        busy;
   logic        done;
   logic        err;

   int          mode = 0;
   logic        vital_kill = 1'b0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   lut_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .loop_en   (loop_en),
      .lut_addr  (lut_addr),
      .lut_dout  (lut_dout),
      .lut_vital (lut_vital),
      .ctrl_a    (ctrl_a),
      .ctrl_b    (ctrl_b),
      .ctrl_c    (ctrl_c),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   function automatic logic [39:0] mk(int dur, int ca, int cb, int cc);
      return {24'(dur), 4'(ca), 4'(cb), 8'(cc)};
   endfunction

   // mode 0: production table; mode 2: one-cycle entry then terminator
   function automatic logic [39:0] tbl(int m, logic [19:0] a);
      if (m == 2) begin
         if (a == 20'd1) return mk(1, 9, 5, 8'h77);
         return mk(0, 1, 2, 8'hAA);
      end
      if (a == 20'd1) return mk(102, 6, 1, 8'h11);
      if (a >= 20'd2 && a <= 20'd9) begin
         if (a[0] == 1'b0) return mk(63, 2, 3, 8'h22);
         return mk(95, 0, 4, 8'h33);
      end
      return mk(0, 0, 0, 8'h55);
   endfunction

   always_comb begin
      lut_dout  = tbl(mode, lut_addr);
      lut_vital = !(vital_kill && (lut_addr == 20'd3));
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end else begin
         $display("ok   %s @cyc %0d: %0h", tag, cyc, got);
      end
   endtask

   // Advance to the falling edge inside cycle n (cycle k follows edge k-1)
   task automatic adv_to(input int n);
      while (cyc < n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      loop_en = 1'b0;
      vital_kill = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cyc = 0;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_addr", 32'(lut_addr), 0);
      check("rst_ctrl", {ctrl_a, ctrl_b, ctrl_c}, 0);
      check("rst_flags", {busy, done, err}, 0);

      // Production table, single pass
      mode = 0;
      start = 1'b1;
      adv_to(1); start = 1'b0;
      check("p_fetch", {busy, 12'(lut_addr)}, {1'b1, 12'd1});
      adv_to(2);   check("p_e1_first", {ctrl_a, ctrl_b, ctrl_c}, {4'd6, 4'd1, 8'h11});
      adv_to(103); check("p_e1_last", 32'(ctrl_a), 6);
      adv_to(104); check("p_e2_first", {ctrl_a, ctrl_b}, {4'd2, 4'd3});
      adv_to(166); check("p_e2_last", 32'(ctrl_a), 2);
      adv_to(167); check("p_e3_first", {ctrl_a, ctrl_b}, {4'd0, 4'd4});
      adv_to(300); start = 1'b1;
      adv_to(301); start = 1'b0;
      adv_to(641); check("p_e9_first", {ctrl_a, ctrl_b}, {4'd0, 4'd4});
      adv_to(735); check("p_pre_done", {busy, done}, {1'b1, 1'b0});
      adv_to(736); check("p_done", {busy, done, err, ctrl_c}, {3'b010, 8'h55});
      adv_to(737); check("p_after", {busy, done, ctrl_c}, {2'b00, 8'h55});

      // Looping playback
      do_reset();
      loop_en = 1'b1;
      start = 1'b1;
      adv_to(1); start = 1'b0;
      adv_to(736); check("l_done1", {busy, done, ctrl_c}, {2'b11, 8'h55});
      adv_to(738); check("l_pass2", {done, ctrl_a, ctrl_c}, {1'b0, 4'd6, 8'h11});
      adv_to(1470); check("l_pre_done2", 32'(done), 0);
      adv_to(1471); check("l_done2", {busy, done}, 2'b11);
      loop_en = 1'b0;

      // Abort mid-run, then restart
      do_reset();
      start = 1'b1;
      adv_to(1); start = 1'b0;
      adv_to(50); abort = 1'b1;
      adv_to(51); abort = 1'b0;
      check("a_outs", {ctrl_a, ctrl_b, ctrl_c}, 0);
      check("a_flags", {busy, done, err}, 0);
      adv_to(60); start = 1'b1;
      adv_to(61); start = 1'b0;
      check("a_restart", {busy, 12'(lut_addr)}, {1'b1, 12'd1});
      adv_to(63); check("a_replay", 32'(ctrl_a), 6);

      // Table not valid when entry 3 is prefetched
      do_reset();
      vital_kill = 1'b1;
      start = 1'b1;
      adv_to(1); start = 1'b0;
      adv_to(166); check("v_before", {busy, err, ctrl_a}, {2'b10, 4'd2});
      adv_to(167); check("v_err", {busy, err, ctrl_a, ctrl_b, ctrl_c}, {2'b01, 16'h0});
      vital_kill = 1'b0;
      adv_to(170); start = 1'b1;
      adv_to(171); start = 1'b0;
      check("v_clear", {busy, err}, 2'b10);

      // Duration-1 entry followed by terminator
      do_reset();
      mode = 2;
      start = 1'b1;
      adv_to(1); start = 1'b0;
      adv_to(2); check("d1_entry", {done, ctrl_a, ctrl_b, ctrl_c}, {1'b0, 4'd9, 4'd5, 8'h77});
      adv_to(3); check("d1_term", {busy, done, ctrl_a, ctrl_b, ctrl_c}, {2'b01, 4'd1, 4'd2, 8'hAA});
      adv_to(4); check("d1_pulse_end", 32'(done), 0);
      adv_to(5); start = 1'b1; abort = 1'b1;
      adv_to(6); start = 1'b0; abort = 1'b0;
      check("sa_idle", {busy, done, ctrl_c}, 0);
      adv_to(8); check("sa_still_idle", 32'(busy), 0);

      // Reset in the middle of playback
      do_reset();
      mode = 0;
      start = 1'b1;
      adv_to(1); start = 1'b0;
      adv_to(20); check("r_running", {busy, ctrl_a}, {1'b1, 4'd6});
      rst = 1'b1;
      adv_to(21); rst = 1'b0;
      check("r_outs", {busy, done, err, ctrl_a, ctrl_b, ctrl_c}, 0);
      check("r_addr", 32'(lut_addr), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
